// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Owns the architectural HI/LO registers beside the E-stage ALU. It runs
//   MULT/MULTU in one extra cycle and DIV/DIVU with a restoring radix-2
//   divider that produces one quotient bit per cycle. It applies MTHI/MTLO
//   writes and holds the F/D/E stages while a multi-cycle operation runs.
//
//   Optional feature (macro HILO_BYPASS_EN):
//     defined   - hi_o/lo_o forward rs_i combinationally during an accepted
//                 MTHI/MTLO cycle.
//     undefined - hi_o/lo_o are pure register outputs.
//
// Ports:
//   clk          in   core clock, rising edge
//   resetn       in   asynchronous reset, active low
//   valid_i      in   E-stage instruction valid (not flushed)
//   hilowrite_i  in   10 = MTHI, 01 = MTLO, 11 = mult/div, 00 = none
//   mdsel_i      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (used when hilowrite_i = 11)
//   rs_i         in   dividend / multiplicand / MTHI-MTLO data
//   rt_i         in   divisor / multiplier
//   flush_i      in   kill of the E stage
//   stall_o      out  hold F/D/E stages
//   hi_o, lo_o   out  current HI / LO
//
// Handshake: there is no ready. An instruction that is valid in IDLE with
// hilowrite_i = 11 starts at once. stall_o stays high until the cycle the
// result is in HI/LO (DONE). The upstream must hold the instruction while
// stall_o is high. Operands are captured on the edge that leaves IDLE.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic [1:0]       hilowrite_i,
  input  logic [1:0]       mdsel_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // opa: multiplicand, or the dividend magnitude that shifts out into the quotient
  // opb: multiplier, or the divisor magnitude
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;    // signed multiply
  logic             qneg_q, qneg_d;  // negate the quotient at the end
  logic             rneg_q, rneg_d;  // negate the remainder at the end

  // Acceptance in IDLE
  logic accept, start, mthi_wr, mtlo_wr;
  assign accept  = (state_q == S_IDLE) && valid_i && !flush_i;
  assign start   = accept && (hilowrite_i == 2'b11);
  assign mthi_wr = accept && (hilowrite_i == 2'b10);
  assign mtlo_wr = accept && (hilowrite_i == 2'b01);

  // Operand magnitudes for a signed DIV. The most-negative value wraps to
  // itself, which is still its correct unsigned magnitude.
  logic             div_signed;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  assign div_signed = ~mdsel_i[0];
  assign rs_mag = (div_signed && rs_i[WIDTH-1]) ? -rs_i : rs_i;
  assign rt_mag = (div_signed && rt_i[WIDTH-1]) ? -rt_i : rt_i;

  // Multiplier: extend both operands to 2W bits. The low 2W bits of the
  // product are then correct for both signed and unsigned forms.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  assign a_ext = sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
  assign b_ext = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
  assign prod  = a_ext * b_ext;

  // One restoring-division step. The partial remainder is always below the
  // divisor, so the shifted value is below 2*divisor. The top bit of the
  // (W+1)-bit difference is therefore set exactly when the trial subtract
  // would go negative.
  logic [WIDTH:0]   shifted, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin;
  assign shifted = {rem_q, opa_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};
  assign qbit    = ~diff[WIDTH];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {opa_q[WIDTH-2:0], qbit};
  assign quo_fin = qneg_q ? -quo_nxt : quo_nxt;
  assign rem_fin = rneg_q ? -rem_nxt : rem_nxt;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_o = 1'b1;
          if (!mdsel_i[1]) begin
            opa_d   = rs_i;
            opb_d   = rt_i;
            sgn_d   = ~mdsel_i[0];
            state_d = S_MUL;
          end else if (rt_i == '0) begin
            // Divide by zero: the result is written on this edge.
            hi_d    = rs_i;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            opa_d   = rs_mag;
            opb_d   = rt_mag;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = div_signed && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
            rneg_d  = div_signed && rs_i[WIDTH-1];
            state_d = S_DIV;
          end
        end else if (mthi_wr) begin
          hi_d = rs_i;
        end else if (mtlo_wr) begin
          lo_d = rs_i;
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          opa_d   = quo_nxt;
          rem_d   = rem_nxt;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            lo_d    = quo_fin;
            hi_d    = rem_fin;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // The stalled instruction retires here. It is never restarted.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

`ifdef HILO_BYPASS_EN
  assign hi_o = mthi_wr ? rs_i : hi_q;
  assign lo_o = mtlo_wr ? rs_i : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         valid_i;
  logic [1:0]   hilowrite_i;
  logic [1:0]   mdsel_i;
  logic [W-1:0] rs_i;
  logic [W-1:0] rt_i;
  logic         flush_i;
  logic         stall_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .valid_i     (valid_i),
    .hilowrite_i (hilowrite_i),
    .mdsel_i     (mdsel_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   md;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    int           exp_stall;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i     = 1'b0;
    hilowrite_i = 2'b00;
    mdsel_i     = 2'($urandom_range(0, 3));
    rs_i        = $urandom;
    rt_i        = $urandom;
    flush_i     = 1'b0;
  endtask

  // Issue one mult/div from IDLE and count the stall cycles. Inputs are
  // scrambled after the start edge to show the operands were captured.
  task automatic run_op(input vec_t v);
    int n;
    @(negedge clk);
    valid_i     = 1'b1;
    hilowrite_i = 2'b11;
    mdsel_i     = v.md;
    rs_i        = v.rs;
    rt_i        = v.rt;
    flush_i     = 1'b0;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) idle_inputs();
      #1;
    end
    check({v.name, " stall"}, W'(n), W'(v.exp_stall));
    check({v.name, " hi"}, hi_o, v.exp_hi);
    check({v.name, " lo"}, lo_o, v.exp_lo);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic mt_write(input logic [1:0] hw, input logic [W-1:0] d);
    @(negedge clk);
    valid_i     = 1'b1;
    hilowrite_i = hw;
    rs_i        = d;
    flush_i     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"mult_neg3x5",    2'b00, 32'hFFFFFFFD, 32'd5,        2,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{"multu_ffx2",     2'b01, 32'hFFFFFFFF, 32'd2,        2,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"div_neg7by2",    2'b10, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_100by7",    2'b11, 32'd100,      32'd7,        33, 32'd2,        32'd14};
    vecs[4]  = '{"div_by_zero",    2'b10, 32'h00001234, 32'd0,        1,  32'h00001234, 32'hFFFFFFFF};
    vecs[5]  = '{"div_minneg_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000};
    vecs[6]  = '{"mult_minneg_sq", 2'b00, 32'h80000000, 32'h80000000, 2,  32'h40000000, 32'h00000000};
    vecs[7]  = '{"divu_max_by1",   2'b11, 32'hFFFFFFFF, 32'd1,        33, 32'h00000000, 32'hFFFFFFFF};
    vecs[8]  = '{"div_7by_neg2",   2'b10, 32'd7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{"multu_small",    2'b01, 32'h12345678, 32'd9,        2,  32'h00000000, 32'hA3D70A38};
    vecs[10] = '{"divu_by_msb",    2'b11, 32'd5,        32'h80000000, 33, 32'h00000005, 32'h00000000};
    vecs[11] = '{"div_negs",       2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 32'hFFFFFFFE, 32'h0000000E};

    // Reset
    resetn = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("reset hi", hi_o, '0);
    check("reset lo", lo_o, '0);
    check("reset stall", W'(stall_o), '0);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven arithmetic
    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Back-to-back MTHI / MTLO, no stall
    mt_write(2'b10, 32'hDEADBEEF);
    #1;
    check("mthi stall", W'(stall_o), '0);
`ifdef HILO_BYPASS_EN
    check("mthi bypass hi", hi_o, 32'hDEADBEEF);
`else
    check("mthi no bypass hi", hi_o, vecs[11].exp_hi);
`endif
    mt_write(2'b01, 32'h5);
    #1;
    check("mtlo stall", W'(stall_o), '0);
    check("mthi hi", hi_o, 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mt hi after", hi_o, 32'hDEADBEEF);
    check("mt lo after", lo_o, 32'h5);

    // Flushed / invalid / none requests do nothing
    @(negedge clk);
    valid_i = 1'b1; hilowrite_i = 2'b11; mdsel_i = 2'b00; rs_i = 32'd3; rt_i = 32'd3; flush_i = 1'b1;
    #1;
    check("flushed start stall", W'(stall_o), '0);
    @(negedge clk);
    valid_i = 1'b1; hilowrite_i = 2'b10; rs_i = 32'h11111111; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; hilowrite_i = 2'b11; mdsel_i = 2'b01; rs_i = 32'd9; rt_i = 32'd9; flush_i = 1'b0;
    #1;
    check("invalid start stall", W'(stall_o), '0);
    @(negedge clk);
    valid_i = 1'b1; hilowrite_i = 2'b00; rs_i = 32'h22222222;
    #1;
    check("none stall", W'(stall_o), '0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("suppressed hi", hi_o, 32'hDEADBEEF);
    check("suppressed lo", lo_o, 32'h5);

    // Flush on DIV iteration 10 leaves HI/LO untouched
    mt_write(2'b10, 32'hAAAA);
    mt_write(2'b01, 32'hBBBB);
    @(negedge clk);
    valid_i = 1'b1; hilowrite_i = 2'b11; mdsel_i = 2'b11; rs_i = 32'd100; rt_i = 32'd7; flush_i = 1'b0;
    #1;
    check("flushdiv start stall", W'(stall_o), 1);
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    #1;
    check("flushdiv busy stall", W'(stall_o), 1);
    flush_i = 1'b1;
    #1;
    check("flushdiv flush stall", W'(stall_o), '0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flushdiv after stall", W'(stall_o), '0);
    check("flushdiv hi", hi_o, 32'hAAAA);
    check("flushdiv lo", lo_o, 32'hBBBB);
    repeat (3) @(negedge clk);
    #1;
    check("flushdiv later hi", hi_o, 32'hAAAA);
    check("flushdiv later lo", lo_o, 32'hBBBB);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    valid_i = 1'b1; hilowrite_i = 2'b11; mdsel_i = 2'b10; rs_i = 32'hFFFFFFF9; rt_i = 32'd2;
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    #1;
    check("pre-reset stall", W'(stall_o), 1);
    #1;
    resetn = 1'b0;
    #1;
    check("midreset hi", hi_o, '0);
    check("midreset lo", lo_o, '0);
    check("midreset stall", W'(stall_o), '0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("postreset stall", W'(stall_o), '0);

    // Unit still works after the aborted operation
    run_op(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
